// File: rtl/rom_loader_pkg.sv
// Shared constants and FSM state encodings for the instruction-ROM loader.
// Imported by rom_loader and its byte packer.
package rom_loader_pkg;

    localparam int ADDRESS_SIZE   = 15;
    localparam int DATA_SIZE      = 16;
    localparam int MEMORY_SIZE    = 32768;
    localparam int BYTES_PER_WORD = 2;

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_LEN_HI  = 4'd1;
    localparam logic [3:0] S_LEN_LO  = 4'd2;
    localparam logic [3:0] S_DATA_HI = 4'd3;
    localparam logic [3:0] S_DATA_LO = 4'd4;
    localparam logic [3:0] S_WRITE   = 4'd5;
    localparam logic [3:0] S_SUM_HI  = 4'd6;
    localparam logic [3:0] S_SUM_LO  = 4'd7;
    localparam logic [3:0] S_FIN     = 4'd8;

endpackage

// File: rtl/rom_loader_byte_pack.sv
// Big-endian byte packer: latches the HI byte, then presents {hi,lo} with a
// one-cycle word_valid on the LO transfer. Shared by length, data and checksum.
module rom_loader_byte_pack
    import rom_loader_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic [7:0]           byte_in,
    input  logic                 take_hi,
    input  logic                 take_lo,
    output logic [DATA_SIZE-1:0] word,
    output logic                 word_valid
);

    localparam int BYTE_W = DATA_SIZE / BYTES_PER_WORD;

    logic [BYTE_W-1:0] hi;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi <= '0;
        end else if (take_hi) begin
            hi <= byte_in;
        end
    end

    assign word       = {hi, byte_in};
    assign word_valid = take_lo;

endmodule

// File: rtl/rom_loader.sv
// Streams a length-prefixed, checksummed byte image into instruction memory
// while holding the CPU in reset.
module rom_loader
    import rom_loader_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [7:0]              byte_in,
    input  logic                    byte_valid,
    output logic                    byte_ready,
    output logic                    mem_we,
    output logic [ADDRESS_SIZE-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]    mem_wdata,
    output logic                    cpu_hold,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [15:0]             words_loaded
);

    logic [3:0]           state;
    logic [15:0]          len;
    logic [DATA_SIZE-1:0] checksum;
    logic                 sum_ok;

    logic                 in_hi;
    logic                 in_lo;
    logic                 transfer;
    logic [DATA_SIZE-1:0] word;
    logic                 word_valid;

    assign in_hi      = (state == S_LEN_HI) || (state == S_DATA_HI) || (state == S_SUM_HI);
    assign in_lo      = (state == S_LEN_LO) || (state == S_DATA_LO) || (state == S_SUM_LO);
    assign byte_ready = in_hi || in_lo;
    assign transfer   = byte_valid && byte_ready;
    // The WRITE state is exactly one cycle long and doubles as the stall slot.
    assign mem_we     = (state == S_WRITE);

    rom_loader_byte_pack u_pack (
        .clk        (clk),
        .reset      (reset),
        .byte_in    (byte_in),
        .take_hi    (transfer && in_hi),
        .take_lo    (transfer && in_lo),
        .word       (word),
        .word_valid (word_valid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            len          <= '0;
            checksum     <= '0;
            sum_ok       <= 1'b0;
            mem_addr     <= '0;
            mem_wdata    <= '0;
            cpu_hold     <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
            error        <= 1'b0;
            words_loaded <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        done         <= 1'b0;
                        error        <= 1'b0;
                        words_loaded <= '0;
                        checksum     <= '0;
                        busy         <= 1'b1;
                        cpu_hold     <= 1'b1;
                        state        <= S_LEN_HI;
                    end
                end
                S_LEN_HI:  if (transfer) state <= S_LEN_LO;
                S_LEN_LO: begin
                    if (word_valid) begin
                        len <= word;
                        if (int'(word) > MEMORY_SIZE) begin
                            error    <= 1'b1;
                            busy     <= 1'b0;
                            cpu_hold <= 1'b0;
                            state    <= S_IDLE;
                        end else if (word == '0) begin
                            state <= S_SUM_HI;
                        end else begin
                            state <= S_DATA_HI;
                        end
                    end
                end
                S_DATA_HI: if (transfer) state <= S_DATA_LO;
                S_DATA_LO: begin
                    if (word_valid) begin
                        mem_wdata <= word;
                        mem_addr  <= words_loaded[ADDRESS_SIZE-1:0];
                        state     <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    checksum     <= checksum + mem_wdata;
                    words_loaded <= words_loaded + 16'd1;
                    state        <= ((words_loaded + 16'd1) == len) ? S_SUM_HI : S_DATA_HI;
                end
                S_SUM_HI:  if (transfer) state <= S_SUM_LO;
                S_SUM_LO: begin
                    if (word_valid) begin
                        sum_ok <= (word == checksum);
                        state  <= S_FIN;
                    end
                end
                S_FIN: begin
                    done     <= sum_ok;
                    error    <= !sum_ok;
                    busy     <= 1'b0;
                    cpu_hold <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_loader.sv
// Directed self-checking bench for rom_loader: nominal, mismatch, zero length,
// overflow, gapped stream with stray start, and reset mid-load.
module tb_rom_loader;
    import rom_loader_pkg::*;

    typedef logic [7:0] bytes_t[$];

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    start;
    logic [7:0]              byte_in;
    logic                    byte_valid;
    logic                    byte_ready;
    logic                    mem_we;
    logic [ADDRESS_SIZE-1:0] mem_addr;
    logic [DATA_SIZE-1:0]    mem_wdata;
    logic                    cpu_hold;
    logic                    busy;
    logic                    done;
    logic                    error;
    logic [15:0]             words_loaded;

    int          errors = 0;
    int          checks = 0;
    int          ready_in_write = 0;
    logic [31:0] wr_addr[$];
    logic [31:0] wr_data[$];

    always #5 clk = ~clk;

    rom_loader dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .byte_in      (byte_in),
        .byte_valid   (byte_valid),
        .byte_ready   (byte_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .words_loaded (words_loaded)
    );

    // Write-port monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (mem_we) begin
            wr_addr.push_back(32'(mem_addr));
            wr_data.push_back(32'(mem_wdata));
            if (byte_ready) ready_in_write++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        byte_in    = b;
        byte_valid = 1'b1;
        while (!byte_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("ready_timeout", 32'(t), 32'd0);
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    task automatic send_stream(input bytes_t s, input int maxgap);
        foreach (s[i]) begin
            send_byte(s[i]);
            if (maxgap > 0) repeat ($urandom_range(0, maxgap)) @(negedge clk);
        end
    endtask

    task automatic wait_idle();
        int t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) check("idle_timeout", 32'(t), 32'd0);
    endtask

    task automatic check_reset_vals(input string p);
        check({p, "_byte_ready"}, 32'(byte_ready), 32'd0);
        check({p, "_mem_we"}, 32'(mem_we), 32'd0);
        check({p, "_mem_addr"}, 32'(mem_addr), 32'd0);
        check({p, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
        check({p, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({p, "_busy"}, 32'(busy), 32'd0);
        check({p, "_done"}, 32'(done), 32'd0);
        check({p, "_error"}, 32'(error), 32'd0);
        check({p, "_words"}, 32'(words_loaded), 32'd0);
    endtask

    // Expected outcome of the two-word image 1234, ABCD.
    task automatic check_two_words(input string p, input logic exp_done);
        check({p, "_done"}, 32'(done), 32'(exp_done));
        check({p, "_error"}, 32'(error), 32'(!exp_done));
        check({p, "_busy"}, 32'(busy), 32'd0);
        check({p, "_cpu_hold"}, 32'(cpu_hold), 32'd0);
        check({p, "_words"}, 32'(words_loaded), 32'd2);
        check({p, "_nwrites"}, 32'(wr_addr.size()), 32'd2);
        if (wr_addr.size() == 2) begin
            check({p, "_addr0"}, wr_addr[0], 32'd0);
            check({p, "_data0"}, wr_data[0], 32'h1234);
            check({p, "_addr1"}, wr_addr[1], 32'd1);
            check({p, "_data1"}, wr_data[1], 32'hABCD);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        byte_in    = 8'h00;
        byte_valid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_vals("rst");
        reset = 1'b0;
        @(negedge clk);

        // Nominal load: 1234 + ABCD = BE01.
        pulse_start();
        check("nom_busy_on", 32'(busy), 32'd1);
        check("nom_hold_on", 32'(cpu_hold), 32'd1);
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01}, 0);
        check("nom_hold_in_fin", 32'(cpu_hold), 32'd1);
        @(negedge clk);
        check_two_words("nom", 1'b1);
        wr_addr.delete();
        wr_data.delete();

        // Checksum mismatch.
        pulse_start();
        check("mis_done_cleared", 32'(done), 32'd0);
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h02}, 0);
        wait_idle();
        check_two_words("mis", 1'b0);
        wr_addr.delete();
        wr_data.delete();

        // Zero length.
        pulse_start();
        check("zero_err_cleared", 32'(error), 32'd0);
        send_stream('{8'h00, 8'h00, 8'h00, 8'h00}, 0);
        wait_idle();
        check("zero_done", 32'(done), 32'd1);
        check("zero_error", 32'(error), 32'd0);
        check("zero_words", 32'(words_loaded), 32'd0);
        check("zero_nwrites", 32'(wr_addr.size()), 32'd0);

        // Length overflow, N = 32769.
        pulse_start();
        send_stream('{8'h80, 8'h01}, 0);
        check("ovf_error", 32'(error), 32'd1);
        check("ovf_busy", 32'(busy), 32'd0);
        check("ovf_hold", 32'(cpu_hold), 32'd0);
        check("ovf_done", 32'(done), 32'd0);
        check("ovf_ready", 32'(byte_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("ovf_ready_later", 32'(byte_ready), 32'd0);
        check("ovf_nwrites", 32'(wr_addr.size()), 32'd0);

        // Gapped stream with a stray start after the first word.
        pulse_start();
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34}, 3);
        pulse_start();
        @(negedge clk);
        check("gap_words_mid", 32'(words_loaded), 32'd1);
        check("gap_busy_mid", 32'(busy), 32'd1);
        send_stream('{8'hAB, 8'hCD, 8'hBE, 8'h01}, 3);
        wait_idle();
        check_two_words("gap", 1'b1);
        check("ready_in_write", 32'(ready_in_write), 32'd0);
        wr_addr.delete();
        wr_data.delete();

        // Reset after the first data word has been written.
        pulse_start();
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34}, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_reset_vals("mid_rst");
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("mid_rst_nwrites", 32'(wr_addr.size()), 32'd1);
        wr_addr.delete();
        wr_data.delete();
        pulse_start();
        send_stream('{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'hBE, 8'h01}, 0);
        wait_idle();
        check_two_words("reload", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rom_loader.md
Name: rom_loader

Overview:
- Writer-side counterpart of the instruction ROM.
- Accepts a byte stream over a valid/ready handshake and assembles big-endian 16-bit instruction words.
- Writes each word sequentially into the instruction-memory write port, starting at address 0.
- Holds the CPU in reset while loading, then verifies a trailing 16-bit checksum.
- Sits between the host serial receiver and the instruction memory's write port.

Parameters:
- ADDRESS_SIZE, 15, instruction memory address width.
- DATA_SIZE, 16, instruction word width; the stream format is fixed at 2 bytes per word.
- MEMORY_SIZE, 32768, number of words in instruction memory; the maximum legal load length.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse that begins a load; ignored while busy=1.
- byte_in  input  8  stream byte.
- byte_valid  input  1  byte_in is valid this cycle.
- byte_ready  output  1  loader accepts a byte this cycle; a transfer occurs when byte_valid&byte_ready.
- mem_we  output  1  instruction memory write enable, one cycle per word.
- mem_addr  output  ADDRESS_SIZE  write address.
- mem_wdata  output  DATA_SIZE  write data.
- cpu_hold  output  1  holds the CPU in reset while a load is in progress.
- busy  output  1  load in progress.
- done  output  1  sticky; the load completed with a matching checksum.
- error  output  1  sticky; length overflow or checksum mismatch.
- words_loaded  output  16  number of words written in the current or last load.

Behaviour:
- Reset values: byte_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, cpu_hold=0, busy=0, done=0, error=0, words_loaded=0. State goes to IDLE; the internal length, checksum and byte latch clear.
- Stream format, in order:
  - LEN_HI, LEN_LO: 16-bit word count N.
  - N pairs of (HI, LO) data bytes.
  - SUM_HI, SUM_LO: checksum, the modulo-2^16 sum of all N data words.
- States: IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, WRITE, SUM_HI, SUM_LO, FIN.
- IDLE:
  - byte_ready=0.
  - On start: clear done, error, words_loaded and the checksum accumulator; set busy=1 and cpu_hold=1; go to LEN_HI.
- LEN_HI, DATA_HI, SUM_HI: byte_ready=1. On a transfer, latch the byte as the upper 8 bits and go to the matching LO state.
- LEN_LO: on a transfer, form N.
  - N > MEMORY_SIZE: set error=1, busy=0, cpu_hold=0; go to IDLE. No writes occur.
  - N = 0: go to SUM_HI.
  - Otherwise: go to DATA_HI.
- DATA_LO: on a transfer, register mem_wdata={hi,lo} and mem_addr=words_loaded[ADDRESS_SIZE-1:0]; go to WRITE.
- WRITE:
  - byte_ready=0 and mem_we=1 for exactly this one cycle.
  - Add mem_wdata to the checksum; increment words_loaded.
  - If the new words_loaded equals N, go to SUM_HI; otherwise go to DATA_HI.
- Throughput: at most one word per 3 cycles; the producer is stalled by byte_ready=0 in WRITE.
- SUM_LO: on a transfer, compare {hi,lo} with the accumulator and go to FIN.
- FIN (one cycle): set done=1 on a match or error=1 on a mismatch; busy=0, cpu_hold=0; go to IDLE.
- No transfer is taken while byte_valid=0; the state holds indefinitely (no timeout).
- Memory contents written before an error are not rolled back. The error flag alone marks the image invalid.
- mem_addr, mem_wdata and words_loaded hold their last values in IDLE.
- start while busy=1 is ignored, with no effect on state or counters.
- start coincident with reset: reset wins.
- Reset mid-load: abort immediately. cpu_hold drops on the next edge; no further mem_we; done=error=0.
- N = MEMORY_SIZE is legal; the final address is MEMORY_SIZE-1, with no wrap.
- The checksum wraps modulo 2^16; carries are discarded.

Decomposition:
- Shared package holds:
  - the loader state enumeration;
  - the constants ADDRESS_SIZE, DATA_SIZE and MEMORY_SIZE;
  - BYTES_PER_WORD=2.
- One natural sub-module, rom_loader_byte_pack, latches the HI byte and emits {hi,lo} with a word_valid pulse. It is reused by the length, data and checksum phases.
- The FSM, counters and checksum stay in rom_loader.

Test Plan:
- Nominal load:
  - Stimulus: start, then bytes 00 02 | 12 34 | AB CD | BE 01.
  - Required response: writes mem[0]=0x1234 and mem[1]=0xABCD, one mem_we each; done=1, error=0, words_loaded=2, cpu_hold falls after FIN.
- Checksum mismatch:
  - Stimulus: the same stream with trailer BE 02.
  - Required response: both words written; error=1, done=0.
- Zero length:
  - Stimulus: bytes 00 00 00 00.
  - Required response: no mem_we; done=1.
- Length overflow:
  - Stimulus: bytes 80 01 (N=32769).
  - Required response: error=1 in the cycle after LEN_LO; no mem_we; byte_ready=0 afterwards.
- Backpressure and gaps:
  - Stimulus: random byte_valid idle gaps plus a start pulse mid-load.
  - Required response: the result matches the gapless run; the extra start is ignored; byte_ready=0 during every WRITE cycle.
- Reset mid-load:
  - Stimulus: assert reset after the 1st data word.
  - Required response: all outputs return to their reset values next cycle; a subsequent full load succeeds.
